weight_memory_stream_loader: RTL
================================

Name: weight_memory_stream_loader

Overview:
- Consumer on the slave side of the AXIS-to-weight-memory bus (data/valid/last/ready).
- Packs incoming bus beats into weight-memory words and drives the weight memory write port at consecutive addresses from a programmed base.
- Checks the stream length against a programmed word count and flags short and long transfers.
- Sits between the DMA-facing stream path and the weight memory BRAM.

Parameters:
- AXIS_BUS_BIT_WIDTH, 64, stream beat width.
- WEIGHT_MEM_BIT_WIDTH, 128, memory word width; integer multiple of AXIS_BUS_BIT_WIDTH.
- WEIGHT_MEM_ADDR_WIDTH, 12, memory address width.
- Local BEATS_PER_WORD = WEIGHT_MEM_BIT_WIDTH / AXIS_BUS_BIT_WIDTH.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  load request pulse; ignored while busy.
- base_addr  in  WEIGHT_MEM_ADDR_WIDTH  first write address; latched on start.
- num_words  in  WEIGHT_MEM_ADDR_WIDTH+1  expected memory words; latched on start.
- s_data  in  AXIS_BUS_BIT_WIDTH  stream beat.
- s_valid  in  1  beat valid.
- s_last  in  1  final beat of transfer.
- s_ready  out  1  loader accepts beat.
- mem_wr_en  out  1  memory write strobe.
- mem_wr_addr  out  WEIGHT_MEM_ADDR_WIDTH  write address.
- mem_wr_data  out  WEIGHT_MEM_BIT_WIDTH  write word.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle completion pulse.
- words_written  out  WEIGHT_MEM_ADDR_WIDTH+1  words written in current/last transfer.
- err_short  out  1  s_last arrived before num_words words.
- err_long  out  1  beats received beyond num_words words.

Behaviour:
- Reset: state IDLE; all outputs 0; partial word discarded; no write issued. Applies mid-transfer.
- FSM states: IDLE, LOAD, DRAIN, DONE.
- s_ready is decoded from the state register only: 1 in LOAD and DRAIN, else 0. No combinational path from s_valid to s_ready.
- A beat is accepted when s_valid && s_ready.
- IDLE:
  - start latches base_addr and num_words, clears words_written, err_short and err_long.
  - num_words != 0 -> LOAD. num_words == 0 -> DONE with no stream interaction.
  - busy = 1 from the cycle after start through the DONE cycle.
- LOAD, packing:
  - Beat k (0..BEATS_PER_WORD-1) of a word goes to bits [k*AXIS_BUS_BIT_WIDTH +: AXIS_BUS_BIT_WIDTH], little-endian lane order.
  - The word completes on beat BEATS_PER_WORD-1 or on s_last, whichever comes first.
- LOAD, write timing:
  - mem_wr_en = 1 for exactly one cycle, on the cycle after the completing beat (latency 1, registered).
  - mem_wr_addr = base_addr + words already written, modulo 2^WEIGHT_MEM_ADDR_WIDTH (wraps).
  - Unfilled lanes of a partial word are zero.
  - words_written increments together with mem_wr_en.
- LOAD, exits on the completing beat:
  - s_last and total words == num_words -> DONE, clean.
  - s_last and total < num_words -> DONE, err_short = 1.
  - No s_last and total == num_words -> DRAIN.
- DRAIN:
  - Accepts and discards beats; no writes.
  - err_long = 1 on the first beat accepted in DRAIN.
  - Beat with s_last -> DONE.
- DONE: done = 1 for one cycle, then IDLE.
- err_short and err_long are sticky until the next accepted start.
- start arriving in the same cycle as done: ignored, because busy is still 1.
- Back-to-back beats are sustained at 1 beat/cycle. No stall is inserted on word completion.

Optional Feature:
- Macro WEIGHT_LOADER_CHECKSUM_EN.
- When defined:
  - Adds output checksum, width AXIS_BUS_BIT_WIDTH.
  - checksum is a running XOR of every beat accepted in LOAD; DRAIN beats are excluded.
  - Cleared to 0 on reset and on accepted start; valid when done pulses.
- When undefined: port and logic are absent; all other behaviour is identical.

Test Plan (defaults: 64-bit bus, 128-bit words, BEATS_PER_WORD = 2):
- Clean load: base_addr 0x010, num_words 3, 6 back-to-back beats B0..B5, last on B5 -> writes at 0x010/0x011/0x012 with data {B1,B0}/{B3,B2}/{B5,B4}, each one cycle after its completing beat. done pulses once, words_written 3, no errors. With the macro defined, checksum = B0^B1^B2^B3^B4^B5.
- Short transfer: num_words 4, 5 beats, last on B4 -> 3 writes, third word {64'h0,B4}, err_short 1, err_long 0, words_written 3.
- Long transfer: num_words 2, 7 beats, last on B6 -> 2 writes only, B4..B6 accepted and dropped, err_long 1, done the cycle after B6.
- Backpressure/idle gaps: clean-load scenario with s_valid toggling every other cycle -> identical writes, addresses and flags. s_ready is 0 in IDLE and DONE.
- Address wrap: base_addr 0xFFF, num_words 2, 4 beats -> writes at 0xFFF then 0x000.
- Reset mid-operation: reset after B0..B2 of the clean load -> no write for the partial word, all outputs 0 next cycle. A new start then loads correctly.

Source files
------------

// File: rtl/weight_memory_stream_loader.sv
// Stream-to-weight-memory loader: packs AXIS beats into memory words written at consecutive addresses.
// Optional running beat checksum output enabled by defining WEIGHT_LOADER_CHECKSUM_EN.
module weight_memory_stream_loader #(
    parameter int unsigned AXIS_BUS_BIT_WIDTH    = 64,
    parameter int unsigned WEIGHT_MEM_BIT_WIDTH  = 128,
    parameter int unsigned WEIGHT_MEM_ADDR_WIDTH = 12
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [WEIGHT_MEM_ADDR_WIDTH-1:0] base_addr,
    input  logic [WEIGHT_MEM_ADDR_WIDTH:0]   num_words,
    input  logic [AXIS_BUS_BIT_WIDTH-1:0]    s_data,
    input  logic                             s_valid,
    input  logic                             s_last,
    output logic                             s_ready,
    output logic                             mem_wr_en,
    output logic [WEIGHT_MEM_ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [WEIGHT_MEM_BIT_WIDTH-1:0]  mem_wr_data,
    output logic                             busy,
    output logic                             done,
    output logic [WEIGHT_MEM_ADDR_WIDTH:0]   words_written,
    output logic                             err_short,
    output logic                             err_long
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    ,
    output logic [AXIS_BUS_BIT_WIDTH-1:0]    checksum
`endif
);

    localparam int unsigned BEATS_PER_WORD = WEIGHT_MEM_BIT_WIDTH / AXIS_BUS_BIT_WIDTH;
    localparam int unsigned LANE_W         = (BEATS_PER_WORD > 1) ? $clog2(BEATS_PER_WORD) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BEATS_PER_WORD - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN,
        DONE
    } state_t;

    state_t                             state_q;
    logic [WEIGHT_MEM_ADDR_WIDTH-1:0]   base_q;
    logic [WEIGHT_MEM_ADDR_WIDTH:0]     num_q;
    logic [WEIGHT_MEM_ADDR_WIDTH:0]     words_q;
    logic [LANE_W-1:0]                  lane_q;
    logic [WEIGHT_MEM_BIT_WIDTH-1:0]    buf_q;
    logic                               wr_en_q;
    logic [WEIGHT_MEM_ADDR_WIDTH-1:0]   wr_addr_q;
    logic [WEIGHT_MEM_BIT_WIDTH-1:0]    wr_data_q;
    logic                               err_short_q;
    logic                               err_long_q;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    logic [AXIS_BUS_BIT_WIDTH-1:0]      csum_q;
`endif

    logic                               load_beat;
    logic                               word_complete;
    logic [WEIGHT_MEM_BIT_WIDTH-1:0]    word_d;
    logic [WEIGHT_MEM_ADDR_WIDTH:0]     words_d;

    // Ready depends on state only, so there is no s_valid -> s_ready path.
    assign s_ready = (state_q == LOAD) || (state_q == DRAIN);
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);

    assign load_beat     = s_valid && (state_q == LOAD);
    assign word_complete = load_beat && (s_last || (lane_q == LAST_LANE));
    assign words_d       = words_q + (WEIGHT_MEM_ADDR_WIDTH+1)'(1);

    // Lanes above the current beat stay zero because buf_q is cleared per word.
    always_comb begin
        word_d = buf_q;
        for (int unsigned k = 0; k < BEATS_PER_WORD; k++) begin
            if (lane_q == LANE_W'(k)) begin
                word_d[k*AXIS_BUS_BIT_WIDTH +: AXIS_BUS_BIT_WIDTH] = s_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            base_q      <= '0;
            num_q       <= '0;
            words_q     <= '0;
            lane_q      <= '0;
            buf_q       <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            wr_en_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        base_q      <= base_addr;
                        num_q       <= num_words;
                        words_q     <= '0;
                        lane_q      <= '0;
                        buf_q       <= '0;
                        err_short_q <= 1'b0;
                        err_long_q  <= 1'b0;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
                        csum_q      <= '0;
`endif
                        state_q     <= (num_words == '0) ? DONE : LOAD;
                    end
                end
                LOAD: begin
                    if (load_beat) begin
`ifdef WEIGHT_LOADER_CHECKSUM_EN
                        csum_q <= csum_q ^ s_data;
`endif
                        if (word_complete) begin
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= base_q + words_q[WEIGHT_MEM_ADDR_WIDTH-1:0];
                            wr_data_q <= word_d;
                            words_q   <= words_d;
                            lane_q    <= '0;
                            buf_q     <= '0;
                            if (s_last) begin
                                err_short_q <= (words_d < num_q);
                                state_q     <= DONE;
                            end else if (words_d == num_q) begin
                                state_q <= DRAIN;
                            end
                        end else begin
                            buf_q  <= word_d;
                            lane_q <= lane_q + LANE_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (s_valid) begin
                        err_long_q <= 1'b1;
                        if (s_last) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_wr_en     = wr_en_q;
    assign mem_wr_addr   = wr_addr_q;
    assign mem_wr_data   = wr_data_q;
    assign words_written = words_q;
    assign err_short     = err_short_q;
    assign err_long      = err_long_q;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    assign checksum      = csum_q;
`endif

endmodule
